// File: rtl/bp_me_mem_cmd_mux_pkg.sv
// Memory message layout and helpers shared by the command mux,
// its round-robin arbiter and its order FIFO.
package bp_me_mem_cmd_mux_pkg;

    localparam int paddr_width_p     = 40;
    localparam int cce_block_width_p = 64;
    localparam int lce_id_width_p    = 4;
    localparam int lce_assoc_p       = 8;

    typedef enum logic [3:0] {
        e_mem_msg_rd      = 4'b0000,
        e_mem_msg_wr      = 4'b0001,
        e_mem_msg_uc_rd   = 4'b0010,
        e_mem_msg_uc_wr   = 4'b0011,
        e_mem_msg_pre     = 4'b0100
    } bp_mem_msg_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0]      lce_id;
        logic [$clog2(lce_assoc_p)-1:0] way_id;
    } bp_mem_payload_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        bp_mem_payload_s              payload;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        bp_mem_msg_e                  msg_type;
    } bp_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_mem_msg_s);

    // clog2 that never collapses to a zero-width index
    function automatic int min1_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_me_mem_cmd_mux_arb.sv
// Round-robin arbiter: searches from last winner + 1 and only moves
// its pointer on a handshake, so a stalled grant holds still.
module bp_me_rr_arb
    import bp_me_mem_cmd_mux_pkg::*;
#(
    parameter int num_req_p = 2,
    localparam int id_width_lp = min1_clog2(num_req_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [num_req_p-1:0]   reqs_i,
    input  logic                   yumi_i,
    output logic [id_width_lp-1:0] grant_id_o,
    output logic                   grant_v_o
);

    logic [id_width_lp-1:0] last_r;
    int                     idx;

    // first requester after the last winner, wrapping around
    always_comb begin
        grant_id_o = '0;
        grant_v_o  = 1'b0;
        idx        = 0;
        for (int i = 1; i <= num_req_p; i++) begin
            idx = int'(last_r) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!grant_v_o && reqs_i[idx]) begin
                grant_v_o  = 1'b1;
                grant_id_o = id_width_lp'(idx);
            end
        end
    end

    // last winner; reset value gives channel 0 first priority
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) last_r <= id_width_lp'(num_req_p - 1);
        else if (yumi_i) last_r <= grant_id_o;
    end

endmodule

// File: rtl/bp_me_mem_cmd_mux_fifo.sv
// Small order FIFO remembering which channel issued each in-flight
// command; occupancy counter resolves the full/empty pointer ambiguity.
module bsg_fifo_1r1w_small
    import bp_me_mem_cmd_mux_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = min1_clog2(els_p);
    localparam int occ_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] rptr_r;
    logic [ptr_width_lp-1:0] wptr_r;
    logic [occ_width_lp-1:0] occ_r;
    logic                    enq;
    logic                    deq;

    // ready depends only on stored occupancy: no dequeue-to-enqueue path
    assign ready_o = (occ_r != occ_width_lp'(els_p));
    assign v_o     = (occ_r != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_r[rptr_r];

    function automatic logic [ptr_width_lp-1:0] ptr_inc(
        input logic [ptr_width_lp-1:0] p
    );
        if (p == ptr_width_lp'(els_p - 1)) return '0;
        return p + ptr_width_lp'(1);
    endfunction

    // storage array, written at the tail on enqueue
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

    // pointers and occupancy
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_r <= '0;
            wptr_r <= '0;
            occ_r  <= '0;
        end else begin
            if (enq) wptr_r <= ptr_inc(wptr_r);
            if (deq) rptr_r <= ptr_inc(rptr_r);
            if (enq & ~deq) occ_r <= occ_r + occ_width_lp'(1);
            else if (deq & ~enq) occ_r <= occ_r - occ_width_lp'(1);
        end
    end

endmodule

// File: rtl/bp_me_mem_cmd_mux.sv
// N-channel memory command merger with in-order response routing,
// global/per-channel outstanding limits and sticky protocol error.
module bp_me_mem_cmd_mux
    import bp_me_mem_cmd_mux_pkg::*;
#(
    parameter int num_channels_p    = 2,
    parameter int max_outstanding_p = 8,
    parameter int channel_credits_p = 4,
    parameter int mem_msg_width_p   = cce_mem_msg_width_lp,
    localparam int chid_width_lp    = min1_clog2(num_channels_p),
    localparam int cred_width_lp    = $clog2(channel_credits_p + 1)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [num_channels_p*mem_msg_width_p-1:0] ch_mem_cmd_i,
    input  logic [num_channels_p-1:0]                 ch_mem_cmd_v_i,
    output logic [num_channels_p-1:0]                 ch_mem_cmd_ready_o,
    output logic [mem_msg_width_p-1:0]                ch_mem_resp_o,
    output logic [num_channels_p-1:0]                 ch_mem_resp_v_o,
    input  logic [num_channels_p-1:0]                 ch_mem_resp_yumi_i,
    output logic [num_channels_p-1:0]                 ch_credits_full_o,
    output logic [num_channels_p-1:0]                 ch_credits_empty_o,
    output logic [mem_msg_width_p-1:0]                mem_cmd_o,
    output logic                                      mem_cmd_v_o,
    input  logic                                      mem_cmd_ready_i,
    input  logic [mem_msg_width_p-1:0]                mem_resp_i,
    input  logic                                      mem_resp_v_i,
    output logic                                      mem_resp_yumi_o,
    output logic                                      error_o
);

    logic [cred_width_lp-1:0] count_r [num_channels_p];
    logic [num_channels_p-1:0] eligible;
    logic [num_channels_p-1:0] head_oh;
    logic [num_channels_p-1:0] inc;
    logic [num_channels_p-1:0] dec;
    logic [chid_width_lp-1:0]  grant;
    logic                      grant_v;
    logic                      cmd_hs;
    logic                      fifo_ready;
    logic                      fifo_v;
    logic [chid_width_lp-1:0]  head;
    logic                      error_r;
    logic                      error_set;

    // a channel may compete only with a free credit and FIFO space
    always_comb begin
        eligible = '0;
        for (int c = 0; c < num_channels_p; c++) begin
            eligible[c] = ~reset_i & ch_mem_cmd_v_i[c] & fifo_ready
                & (count_r[c] < cred_width_lp'(channel_credits_p));
        end
    end

    bp_me_rr_arb #(
        .num_req_p (num_channels_p)
    ) arb (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .reqs_i     (eligible),
        .yumi_i     (cmd_hs),
        .grant_id_o (grant),
        .grant_v_o  (grant_v)
    );

    assign mem_cmd_v_o = grant_v;
    assign cmd_hs      = grant_v & mem_cmd_ready_i;

    // command mux and ready fan-out to the granted channel only
    always_comb begin
        mem_cmd_o          = '0;
        ch_mem_cmd_ready_o = '0;
        inc                = '0;
        for (int c = 0; c < num_channels_p; c++) begin
            if (grant == chid_width_lp'(c)) begin
                mem_cmd_o = ch_mem_cmd_i[c*mem_msg_width_p +: mem_msg_width_p];
                ch_mem_cmd_ready_o[c] = eligible[c] & mem_cmd_ready_i;
                inc[c] = cmd_hs;
            end
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p (chid_width_lp),
        .els_p   (max_outstanding_p)
    ) order_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (cmd_hs),
        .ready_o (fifo_ready),
        .data_i  (grant),
        .v_o     (fifo_v),
        .data_o  (head),
        .yumi_i  (mem_resp_yumi_o)
    );

    // response steering to the channel at the FIFO head
    always_comb begin
        head_oh = '0;
        for (int c = 0; c < num_channels_p; c++) begin
            head_oh[c] = fifo_v & (head == chid_width_lp'(c));
        end
    end

    assign ch_mem_resp_o   = mem_resp_i;
    assign ch_mem_resp_v_o = mem_resp_v_i ? head_oh : '0;
    assign mem_resp_yumi_o = |(ch_mem_resp_yumi_i & ch_mem_resp_v_o);
    assign dec             = mem_resp_yumi_o ? head_oh : '0;

    // per-channel in-flight counters; issue and retire together cancel
    for (genvar c = 0; c < num_channels_p; c++) begin : g_cred
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                count_r[c] <= '0;
            end else if (inc[c] & ~dec[c]) begin
                count_r[c] <= count_r[c] + cred_width_lp'(1);
            end else if (dec[c] & ~inc[c]) begin
                count_r[c] <= count_r[c] - cred_width_lp'(1);
            end
        end

        assign ch_credits_full_o[c]  =
            (count_r[c] == cred_width_lp'(channel_credits_p));
        assign ch_credits_empty_o[c] = (count_r[c] == '0);
    end

    assign error_set = (mem_resp_v_i & ~fifo_v)
                     | (|(ch_mem_resp_yumi_i & ~head_oh));

    // sticky protocol error flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) error_r <= 1'b0;
        else if (error_set) error_r <= 1'b1;
    end

    assign error_o = error_r;

endmodule
